// File: rtl/mult_seq_pkg.sv
// Shared definitions for the multiplier load sequencer and for the display
// logic that decodes its State output onto LEDR.
//   seqState_t   FSM state encodings (WAIT_A, WAIT_B, RUN, DONE)
//   LATENCY_MAX  largest legal multiplier latency in cycles (legal range 1..15)
//   COUNT_W      latency down-counter width, sized to hold LATENCY_MAX
package mult_seq_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_A = 2'b00,
      ST_WAIT_B = 2'b01,
      ST_RUN    = 2'b10,
      ST_DONE   = 2'b11
   } seqState_t;

   localparam int LATENCY_MAX = 15;
   localparam int COUNT_W     = $clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/load_edge_sync.sv
// Synchronizes the raw Load button into the Clk domain and turns each rising
// edge into a single-cycle pulse. A button held high yields exactly one pulse.
// Ports:
//   Clk          rising-edge clock
//   Reset        asynchronous active-low reset, clears every flop
//   loadRaw_i    raw button level, asynchronous to Clk
//   loadPulse_o  one-cycle pulse on a 0->1 of the last synchronizer stage
module load_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic Clk,
   input  logic Reset,
   input  logic loadRaw_i,
   output logic loadPulse_o
);

   logic [SYNC_STAGES-1:0] loadSync_q;
   logic                   loadEdge_q;

   // Shift chain for metastability settling; the extra edge flop holds the
   // previous value of the last stage so a rising edge can be detected.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         loadSync_q <= '0;
         loadEdge_q <= 1'b0;
      end else begin
         loadSync_q <= {loadSync_q[SYNC_STAGES-2:0], loadRaw_i};
         loadEdge_q <= loadSync_q[SYNC_STAGES-1];
      end
   end

   assign loadPulse_o = loadSync_q[SYNC_STAGES-1] & ~loadEdge_q;

endmodule

// File: rtl/multiplier_load_sequencer.sv
// Sequences operand entry and product capture for the shared multiplier.
// One switch bus and one Load button enter A then B; the block then waits
// LATENCY cycles for the multiplier and latches its full-width product.
// Ports:
//   Clk     rising-edge clock
//   Reset   asynchronous active-low reset
//   Input   operand switches, sampled on the internal load pulse
//   Load    raw Load button, asynchronous to Clk
//   Clear   synchronous level clear back to WAIT_A, beats a same-cycle load
//   Mult_Q  product returned by the multiplier datapath
//   Op_A    registered operand A
//   Op_B    registered operand B
//   P       latched product, held until the next capture
//   Busy    high while in RUN
//   Done    high while in DONE
//   State   FSM state for LED display
module multiplier_load_sequencer
   import mult_seq_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int LATENCY     = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [WIDTH-1:0]     Input,
   input  logic                 Load,
   input  logic                 Clear,
   input  logic [2*WIDTH-1:0]   Mult_Q,
   output logic [WIDTH-1:0]     Op_A,
   output logic [WIDTH-1:0]     Op_B,
   output logic [2*WIDTH-1:0]   P,
   output logic                 Busy,
   output logic                 Done,
   output logic [1:0]           State
);

   localparam logic [COUNT_W-1:0] LAT_LOAD = COUNT_W'(LATENCY);

   logic                 loadPulse;
   seqState_t            state_q, state_d;
   logic [WIDTH-1:0]     opA_q, opA_d;
   logic [WIDTH-1:0]     opB_q, opB_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   load_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) uLoadSync (
      .Clk         (Clk),
      .Reset       (Reset),
      .loadRaw_i   (Load),
      .loadPulse_o (loadPulse)
   );

   // Next-state logic. Clear overrides everything, so a load pulse arriving
   // in the same cycle is simply lost. In RUN the pulse is ignored, and the
   // product is sampled on the last counted cycle so RUN spans LATENCY cycles.
   always_comb begin
      state_d = state_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      p_d     = p_q;
      count_d = count_q;
      if (Clear) begin
         state_d = ST_WAIT_A;
         opA_d   = '0;
         opB_d   = '0;
         p_d     = '0;
         count_d = '0;
      end else begin
         case (state_q)
            ST_WAIT_A: begin
               if (loadPulse) begin
                  opA_d   = Input;
                  state_d = ST_WAIT_B;
               end
            end
            ST_WAIT_B: begin
               if (loadPulse) begin
                  opB_d   = Input;
                  count_d = LAT_LOAD;
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               count_d = count_q - 1'b1;
               if (count_q == COUNT_W'(1)) begin
                  p_d     = Mult_Q;
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (loadPulse) begin
                  opA_d   = Input;
                  state_d = ST_WAIT_B;
               end
            end
         endcase
      end
   end

   // Busy and Done are decoded from the next state so that, once registered,
   // they line up with State on the same edge and can never both be high.
   always_comb begin
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // All sequencer state lives in this one register bank; reset is
   // asynchronous and takes effect immediately, even in the middle of RUN.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_WAIT_A;
         opA_q   <= '0;
         opB_q   <= '0;
         p_q     <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         p_q     <= p_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Op_A  = opA_q;
   assign Op_B  = opB_q;
   assign P     = p_q;
   assign Busy  = busy_q;
   assign Done  = done_q;
   assign State = state_q;

endmodule

// File: tb/tb_multiplier_load_sequencer.sv
// Directed bench for multiplier_load_sequencer. Two instances share all
// stimulus: lat1 (LATENCY=1) and lat4 (LATENCY=4). Each gets its own model
// multiplier whose product is ready by the LATENCY-th edge after Op_B loads.
// Inputs change on the falling edge and outputs are sampled there too.
module tb_multiplier_load_sequencer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [7:0]  Input;
   logic        Load;
   logic        Clear;

   logic [15:0] multQ1, multQ4;
   logic [7:0]  opA1, opB1, opA4, opB4;
   logic [15:0] p1, p4;
   logic        busy1, done1, busy4, done4;
   logic [1:0]  state1, state4;

   logic [15:0] pipe4 [3] = '{16'h0, 16'h0, 16'h0};

   int assertCount = 0;
   int failCount   = 0;

   always #5 Clk = ~Clk;

   // Model multipliers: combinational for LATENCY=1, three register stages
   // for LATENCY=4 so the product is valid at the fourth edge after Op_B.
   assign multQ1 = 16'(opA1) * 16'(opB1);
   always @(posedge Clk) begin
      pipe4[0] <= 16'(opA4) * 16'(opB4);
      pipe4[1] <= pipe4[0];
      pipe4[2] <= pipe4[1];
   end
   assign multQ4 = pipe4[2];

   multiplier_load_sequencer #(.WIDTH(8), .LATENCY(1), .SYNC_STAGES(2)) lat1 (
      .Clk(Clk), .Reset(Reset), .Input(Input), .Load(Load), .Clear(Clear),
      .Mult_Q(multQ1), .Op_A(opA1), .Op_B(opB1), .P(p1),
      .Busy(busy1), .Done(done1), .State(state1)
   );

   multiplier_load_sequencer #(.WIDTH(8), .LATENCY(4), .SYNC_STAGES(2)) lat4 (
      .Clk(Clk), .Reset(Reset), .Input(Input), .Load(Load), .Clear(Clear),
      .Mult_Q(multQ4), .Op_A(opA4), .Op_B(opB4), .P(p4),
      .Busy(busy4), .Done(done4), .State(state4)
   );

   task automatic checkOutput(input string tag, input logic [15:0] obs,
                              input logic [15:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // Press Load with the given switch value; returns on the falling edge
   // right after the capturing rising edge, with the button released.
   task automatic applyStimulus(input logic [7:0] value);
      Input = value;
      Load  = 1'b1;
      tick(3);
      Load  = 1'b0;
   endtask

   initial begin
      Reset = 1'b0;
      Input = 8'h00;
      Load  = 1'b0;
      Clear = 1'b0;
      #1;
      checkOutput("rst_state", 16'(state1), 16'h0);
      checkOutput("rst_opA",   16'(opA1),   16'h0);
      checkOutput("rst_opB",   16'(opB1),   16'h0);
      checkOutput("rst_P",     p1,          16'h0);
      checkOutput("rst_busy",  16'(busy1),  16'h0);
      checkOutput("rst_done",  16'(done1),  16'h0);
      tick(2);
      Reset = 1'b1;
      tick(2);

      $display("[TB] basic 0x0C * 0x0D, LATENCY=1");
      applyStimulus(8'h0C);
      checkOutput("t1_opA",   16'(opA1),   16'h000C);
      checkOutput("t1_stB",   16'(state1), 16'h1);
      tick(2);
      applyStimulus(8'h0D);
      checkOutput("t1_opB",   16'(opB1),   16'h000D);
      checkOutput("t1_stRun", 16'(state1), 16'h2);
      checkOutput("t1_busy",  16'(busy1),  16'h1);
      tick(1);
      checkOutput("t1_P",     p1,          16'h009C);
      checkOutput("t1_done",  16'(done1),  16'h1);
      checkOutput("t1_stD",   16'(state1), 16'h3);
      checkOutput("t1_busy0", 16'(busy1),  16'h0);

      $display("[TB] full-width and zero products");
      tick(2);
      applyStimulus(8'hFF);
      checkOutput("t2_opA",   16'(opA1),   16'h00FF);
      checkOutput("t2_stB",   16'(state1), 16'h1);
      checkOutput("t2_done0", 16'(done1),  16'h0);
      checkOutput("t2_Phold", p1,          16'h009C);
      tick(2);
      applyStimulus(8'hFF);
      tick(1);
      checkOutput("t2_Pff",   p1,          16'hFE01);
      tick(2);
      applyStimulus(8'h00);
      tick(2);
      applyStimulus(8'h7B);
      tick(1);
      checkOutput("t2_Pzero", p1,          16'h0000);
      checkOutput("t2_done",  16'(done1),  16'h1);

      $display("[TB] held Load gives a single capture");
      Clear = 1'b1;
      tick(1);
      Clear = 1'b0;
      checkOutput("t3_clrSt", 16'(state1), 16'h0);
      checkOutput("t3_clrA",  16'(opA1),   16'h0);
      checkOutput("t3_clrP",  p1,          16'h0);
      Input = 8'h5A;
      Load  = 1'b1;
      tick(3);
      checkOutput("t3_opA",   16'(opA1),   16'h005A);
      Input = 8'h11;
      for (int i = 0; i < 17; i++) begin
         tick(1);
         checkOutput("t3_holdSt", 16'(state1), 16'h1);
      end
      Load = 1'b0;
      checkOutput("t3_opAkeep", 16'(opA1), 16'h005A);
      checkOutput("t3_opBkeep", 16'(opB1), 16'h0000);
      tick(3);

      $display("[TB] Clear beats a same-cycle load pulse");
      Input = 8'h77;
      Load  = 1'b1;
      tick(2);
      Clear = 1'b1;
      tick(1);
      Clear = 1'b0;
      checkOutput("t4_st",    16'(state1), 16'h0);
      checkOutput("t4_opA",   16'(opA1),   16'h0);
      checkOutput("t4_opB",   16'(opB1),   16'h0);
      tick(3);
      checkOutput("t4_stKeep", 16'(state1), 16'h0);
      Load = 1'b0;
      tick(3);

      $display("[TB] reset in the middle of RUN, LATENCY=4");
      Reset = 1'b0;
      tick(1);
      Reset = 1'b1;
      tick(2);
      applyStimulus(8'h0C);
      tick(2);
      applyStimulus(8'h0D);
      checkOutput("t5_stRun", 16'(state4), 16'h2);
      checkOutput("t5_busy",  16'(busy4),  16'h1);
      tick(1);
      checkOutput("t5_stRun2", 16'(state4), 16'h2);
      Reset = 1'b0;
      #1;
      checkOutput("t5_st",    16'(state4), 16'h0);
      checkOutput("t5_opA",   16'(opA4),   16'h0);
      checkOutput("t5_opB",   16'(opB4),   16'h0);
      checkOutput("t5_P",     p4,          16'h0);
      checkOutput("t5_busy0", 16'(busy4),  16'h0);
      checkOutput("t5_done0", 16'(done4),  16'h0);
      @(negedge Clk);
      Reset = 1'b1;
      tick(8);
      checkOutput("t5_noDone", 16'(done4),  16'h0);
      checkOutput("t5_stIdle", 16'(state4), 16'h0);

      $display("[TB] Load during RUN is dropped, LATENCY=4");
      applyStimulus(8'h0C);
      tick(2);
      applyStimulus(8'h0D);
      Input = 8'h55;
      Load  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checkOutput("t6_run", 16'(state4), 16'h2);
      end
      Load = 1'b0;
      tick(1);
      checkOutput("t6_stD",   16'(state4), 16'h3);
      checkOutput("t6_done",  16'(done4),  16'h1);
      checkOutput("t6_busy0", 16'(busy4),  16'h0);
      checkOutput("t6_P",     p4,          16'h009C);
      checkOutput("t6_opA",   16'(opA4),   16'h000C);
      tick(2);
      applyStimulus(8'h03);
      checkOutput("t6_newA",  16'(opA4),   16'h0003);
      checkOutput("t6_doneF", 16'(done4),  16'h0);
      checkOutput("t6_Pheld", p4,          16'h009C);
      checkOutput("t6_stB",   16'(state4), 16'h1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
